sram: RTL and testbench
=======================

// Module: sram
// PURPOSE
//  Behavioural single-clock SRAM array with 1 read port and 1 write port.
//  - Depth 2^LOGDEPTH rows; each row is WIDTH bits.
//  - Writes have per-word enables, one enable per WORDSIZE-bit lane.
//  - Serves as the data store behind the L1 instruction cache: one cache block per row.
//  - Row address = {set, index}.
// PARAMETERS
//  WORDSIZE  64   bits per write lane (word)
//  WIDTH     512  bits per row; must be a multiple of WORDSIZE
//  LOGDEPTH  9    log2 of row count (512 rows)
//  Derived: LANES = WIDTH/WORDSIZE (8)
// PORTS
//  clk          in   1         single clock; all state changes on posedge
//  reset        in   1         synchronous, active-high
//  readAddr     in   LOGDEPTH  read row address
//  readData     out  WIDTH     read row data
//  writeAddr    in   LOGDEPTH  write row address
//  writeData    in   WIDTH     write row data; lane i = bits [i*WORDSIZE +: WORDSIZE]
//  writeEnable  in   LANES     per-lane write enable; bit i gates lane i
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//  - Reset: at a posedge with reset=1, every row clears to 0.
//    - All writes in that cycle are ignored.
//    - readData reflects the cleared array (0) after that edge.
//  - Write: at posedge with reset=0, for each i where writeEnable[i]=1, mem[writeAddr] lane i <= writeData lane i.
//    - Lanes with enable=0 keep their old value.
//    - writeEnable=0 means no state change.
//  - Read (default, flow-through): readData = mem[readAddr] combinationally, zero-cycle latency.
//    - A client that registers readAddr at edge N samples valid data at edge N+1.
//  - Read-during-write, same row: before the edge readData shows the old contents.
//    After the edge it shows the merged new contents; there is no write-to-read bypass.
//  - Address width equals LOGDEPTH, so every address is in range and no wrap handling is needed.
//  - Every write lands in the addressed row only. No other row changes.
//  - Elaboration check: WIDTH % WORDSIZE != 0 or LOGDEPTH < 1 -> $fatal.
//  - No handshake; the array accepts one read and one write every cycle.
// CONFIGURATION
//  SRAM_OUT_REG_EN defined: readData is registered.
//    - readData <= mem[readAddr] at each posedge, using the array state before that edge's write.
//    - Latency is 1 cycle.
//    - Reset clears the output register to 0.
//  SRAM_OUT_REG_EN undefined (default): flow-through read as above.
//    - Required by the I-cache, which uses zero extra delay at LOGDEPTH=9.
// STRUCTURE
//  - Package sram_pkg: default WORDSIZE/WIDTH/LOGDEPTH constants and lane_of() slice helper.
//  - Sub-module sram_lane (WORDSIZE x 2^LOGDEPTH): one instance per lane, generated LANES times.
//    - Each instance has its own enable bit, a shared writeAddr/readAddr, and its own reset clear.
//    - The top level concatenates the lane outputs into readData.
// TESTING
//  1. Reset then read: reset=1 one cycle, then readAddr=0x000, 0x1FF -> readData=0.
//  2. Full write: writeAddr=0x05, writeData={8{64'hDEAD_BEEF_0000_0005}}, writeEnable=8'hFF.
//     Next cycle readAddr=0x05 -> same value. readAddr=0x04 -> 0.
//  3. Partial write: row 0x05 full as above, then writeEnable=8'h81 with writeData=all-ones.
//     Lanes 0 and 7 become 64'hFFFF_FFFF_FFFF_FFFF; lanes 1-6 stay 64'hDEAD_BEEF_0000_0005.
//  4. Same-row read/write: readAddr=writeAddr=0x10, old=0, write 0xA5 pattern with enable 8'hFF.
//     Same cycle readData=0; after edge = 0xA5 pattern (with SRAM_OUT_REG_EN: one cycle later).
//  5. Boundary rows: write 0x1FF and 0x000 with distinct data.
//     Both read back correctly; no aliasing between them.
//  6. Reset mid-operation: reset=1 together with writeEnable=8'hFF to row 0x20.
//     Row 0x20 reads 0; previously written rows read 0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared defaults and helpers for the I-cache data array (sram).
package sram_pkg;
   localparam int DEF_WORDSIZE = 64;
   localparam int DEF_WIDTH    = 512;
   localparam int DEF_LOGDEPTH = 9;
   localparam int DEF_LANES    = DEF_WIDTH / DEF_WORDSIZE;

   function automatic logic [DEF_WORDSIZE-1:0] lane_of(input logic [DEF_WIDTH-1:0] row,
                                                       input int unsigned lane);
      return row[lane*DEF_WORDSIZE +: DEF_WORDSIZE];
   endfunction
endpackage

// File: rtl/sram_lane.sv
// One WORDSIZE-bit lane of the sram array; flow-through read unless SRAM_OUT_REG_EN.
module sram_lane #(
   parameter int WORDSIZE = 64,
   parameter int LOGDEPTH = 9
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                we,
   input  logic [LOGDEPTH-1:0] writeAddr,
   input  logic [WORDSIZE-1:0] writeData,
   input  logic [LOGDEPTH-1:0] readAddr,
   output logic [WORDSIZE-1:0] readData
);
   localparam int DEPTH = 1 << LOGDEPTH;

   logic [WORDSIZE-1:0] mem [DEPTH];

   // Reset wins over a coincident write: the whole lane clears.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      end else if (we) begin
         mem[writeAddr] <= writeData;
      end
   end

`ifdef SRAM_OUT_REG_EN
   // Samples pre-edge contents, so same-row writes show up one cycle later.
   always_ff @(posedge clk) begin
      if (reset) readData <= '0;
      else       readData <= mem[readAddr];
   end
`else
   assign readData = mem[readAddr];
`endif
endmodule

// File: rtl/sram.sv
// I-cache data store: 1R1W row array split into per-lane banks.
// Define SRAM_OUT_REG_EN for a registered (1-cycle) read port.
module sram
   import sram_pkg::*;
#(
   parameter int WORDSIZE = DEF_WORDSIZE,
   parameter int WIDTH    = DEF_WIDTH,
   parameter int LOGDEPTH = DEF_LOGDEPTH,
   parameter int LANES    = WIDTH / WORDSIZE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [LOGDEPTH-1:0] readAddr,
   output logic [WIDTH-1:0]    readData,
   input  logic [LOGDEPTH-1:0] writeAddr,
   input  logic [WIDTH-1:0]    writeData,
   input  logic [LANES-1:0]    writeEnable
);
   if ((WIDTH % WORDSIZE) != 0 || LOGDEPTH < 1) begin : g_bad_cfg
      $fatal(1, "sram: WIDTH must be a multiple of WORDSIZE and LOGDEPTH >= 1");
   end

   typedef struct packed {
      logic [LOGDEPTH-1:0]             addr;
      logic [LANES-1:0][WORDSIZE-1:0]  data;
      logic [LANES-1:0]                en;
   } wr_req_t;

   wr_req_t                        wr_req;
   logic [LANES-1:0][WORDSIZE-1:0] rd_lanes;

   assign wr_req.addr = writeAddr;
   assign wr_req.data = writeData;
   assign wr_req.en   = writeEnable;
   assign readData    = rd_lanes;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sram_lane #(
         .WORDSIZE (WORDSIZE),
         .LOGDEPTH (LOGDEPTH)
      ) u_lane (
         .clk       (clk),
         .reset     (reset),
         .we        (wr_req.en[i]),
         .writeAddr (wr_req.addr),
         .writeData (wr_req.data[i]),
         .readAddr  (readAddr),
         .readData  (rd_lanes[i])
      );
   end
endmodule

// File: tb/tb_sram.sv
// Randomized and directed checks of sram against a row-array reference model.
module tb_sram;
   import sram_pkg::*;
   localparam int W  = DEF_WIDTH;
   localparam int AW = DEF_LOGDEPTH;
   localparam int L  = DEF_LANES;
   localparam int WS = DEF_WORDSIZE;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] readAddr, writeAddr;
   logic [W-1:0]  readData, writeData;
   logic [L-1:0]  writeEnable;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] model [DEPTH];
   logic [W-1:0] out_q;
   bit           inited = 1'b0;

   always #5 clk = ~clk;

   sram dut (
      .clk         (clk),
      .reset       (reset),
      .readAddr    (readAddr),
      .readData    (readData),
      .writeAddr   (writeAddr),
      .writeData   (writeData),
      .writeEnable (writeEnable)
   );

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] cur_exp(input logic [AW-1:0] ra);
`ifdef SRAM_OUT_REG_EN
      return out_q;
`else
      return model[ra];
`endif
   endfunction

   // One clock cycle: drive, check the pre-edge read, then advance the model at the edge.
   task automatic cyc(input string tag, input logic r, input logic [AW-1:0] ra,
                      input logic [AW-1:0] wa, input logic [W-1:0] wd, input logic [L-1:0] we);
      logic [W-1:0] mask;
      @(negedge clk);
      reset = r; readAddr = ra; writeAddr = wa; writeData = wd; writeEnable = we;
      #1;
      if (inited) chk(tag, readData, cur_exp(ra));
      @(posedge clk);
      out_q = r ? '0 : model[ra];
      if (r) begin
         for (int i = 0; i < DEPTH; i++) model[i] = '0;
         inited = 1'b1;
      end else begin
         mask = '0;
         for (int l = 0; l < L; l++) if (we[l]) mask[l*WS +: WS] = '1;
         model[wa] = (model[wa] & ~mask) | (wd & mask);
      end
   endtask

   logic [W-1:0] pat_dead, pat_a5, exp_part, rnd;
   logic [AW-1:0] ra_r, wa_r;

   initial begin
      pat_dead = {L{64'hDEAD_BEEF_0000_0005}};
      pat_a5   = {(W/8){8'hA5}};
      exp_part = {64'hFFFF_FFFF_FFFF_FFFF, {6{64'hDEAD_BEEF_0000_0005}}, 64'hFFFF_FFFF_FFFF_FFFF};
      reset = 1'b1; readAddr = '0; writeAddr = '0; writeData = '0; writeEnable = '0;

      // reset then read extremes
      cyc("rst", 1'b1, 9'h000, 9'h000, pat_dead, 8'hFF);
      cyc("rd_000", 1'b0, 9'h000, 9'h000, '0, 8'h00);
      cyc("rd_1ff", 1'b0, 9'h1FF, 9'h000, '0, 8'h00);
      cyc("rd_1ff_b", 1'b0, 9'h1FF, 9'h000, '0, 8'h00);
      #1 chk("rst_zero", readData, '0);

      // full write, then neighbour stays clear
      cyc("wr_05", 1'b0, 9'h004, 9'h005, pat_dead, 8'hFF);
      cyc("rd_05", 1'b0, 9'h005, 9'h000, '0, 8'h00);
      cyc("rd_04", 1'b0, 9'h004, 9'h000, '0, 8'h00);

      // partial lane write
      cyc("part_05", 1'b0, 9'h005, 9'h005, '1, 8'h81);
      cyc("rd_05p", 1'b0, 9'h005, 9'h000, '0, 8'h00);
      cyc("rd_05p2", 1'b0, 9'h005, 9'h000, '0, 8'h00);
      #1;
      chk("part_row", readData, exp_part);
      chk("part_lane0", W'(lane_of(readData, 0)), W'(64'hFFFF_FFFF_FFFF_FFFF));
      chk("part_lane3", W'(lane_of(readData, 3)), W'(64'hDEAD_BEEF_0000_0005));

      // same-row read during write
      cyc("rw_10", 1'b0, 9'h010, 9'h010, pat_a5, 8'hFF);
      cyc("rw_10_a", 1'b0, 9'h010, 9'h000, '0, 8'h00);
      cyc("rw_10_b", 1'b0, 9'h010, 9'h000, '0, 8'h00);
      #1 chk("rw_10_val", readData, pat_a5);

      // boundary rows
      rnd = {16{$urandom()}};
      cyc("wr_1ff", 1'b0, 9'h000, 9'h1FF, rnd, 8'hFF);
      cyc("wr_000", 1'b0, 9'h1FF, 9'h000, ~rnd, 8'hFF);
      cyc("bd_1ff", 1'b0, 9'h1FF, 9'h000, '0, 8'h00);
      cyc("bd_000", 1'b0, 9'h000, 9'h000, '0, 8'h00);
      cyc("bd_000b", 1'b0, 9'h000, 9'h000, '0, 8'h00);
      #1 chk("bd_000_val", readData, ~rnd);

      // reset mid-operation overrides a write
      cyc("rst_w20", 1'b1, 9'h005, 9'h020, pat_a5, 8'hFF);
      cyc("rst_rd20", 1'b0, 9'h020, 9'h000, '0, 8'h00);
      cyc("rst_rd05", 1'b0, 9'h005, 9'h000, '0, 8'h00);
      cyc("rst_rd10", 1'b0, 9'h010, 9'h000, '0, 8'h00);
      cyc("rst_rd1ff", 1'b0, 9'h1FF, 9'h000, '0, 8'h00);
      cyc("rst_rd1ffb", 1'b0, 9'h1FF, 9'h000, '0, 8'h00);
      #1 chk("rst_mid_zero", readData, '0);

      // random traffic over a small address pool to force collisions
      for (int n = 0; n < 600; n++) begin
         for (int k = 0; k < W/32; k++) rnd[k*32 +: 32] = $urandom();
         ra_r = ($urandom_range(0, 7) == 0) ? 9'h1FF : AW'($urandom_range(0, 15));
         wa_r = ($urandom_range(0, 7) == 0) ? 9'h1FF : AW'($urandom_range(0, 15));
         cyc("rand", ($urandom_range(0, 99) == 0), ra_r, wa_r, rnd, L'($urandom()));
      end
      cyc("tail", 1'b0, 9'h000, 9'h000, '0, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
